// File: rtl/mac_pkg.sv
// Shared definitions for the matrix-multiply issue block: FSM states and
// width helpers for addresses and the full-width product.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

    localparam int DEF_DIM = 4;
    localparam int DEF_DW  = 32;

    // A bound of 1 still needs a one-bit address port.
    function automatic int addr_w(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/mac_addr_counter.sv
// Nested i/j/k index counter: k innermost, then j, then i, each wrapping at
// its bound-1 and carrying outward. last flags the final (M-1,N-1,K-1) point.
module mac_addr_counter
    import mac_pkg::*;
#(
    parameter int M = 4,
    parameter int K = 4,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    output logic [addr_w(M)-1:0] i,
    output logic [addr_w(N)-1:0] j,
    output logic [addr_w(K)-1:0] k,
    output logic                 last
);

    localparam int AW_M = addr_w(M);
    localparam int AW_N = addr_w(N);
    localparam int AW_K = addr_w(K);
    localparam logic LAST_AT_ZERO = ((M == 1) && (N == 1) && (K == 1)) ? 1'b1 : 1'b0;

    logic [AW_M-1:0] i_nxt_s;
    logic [AW_N-1:0] j_nxt_s;
    logic [AW_K-1:0] k_nxt_s;
    logic            last_nxt_s;
    logic            i_wrap_s;
    logic            j_wrap_s;
    logic            k_wrap_s;

    assign i_wrap_s = (i == AW_M'(M - 1));
    assign j_wrap_s = (j == AW_N'(N - 1));
    assign k_wrap_s = (k == AW_K'(K - 1));

    // Next-index computation with ripple carry k -> j -> i
    always_comb begin
        i_nxt_s = i;
        j_nxt_s = j;
        k_nxt_s = k;
        if (enable) begin
            if (k_wrap_s) begin
                k_nxt_s = {AW_K{1'b0}};
                if (j_wrap_s) begin
                    j_nxt_s = {AW_N{1'b0}};
                    if (i_wrap_s) begin
                        i_nxt_s = {AW_M{1'b0}};
                    end else begin
                        i_nxt_s = i + AW_M'(1);
                    end
                end else begin
                    j_nxt_s = j + AW_N'(1);
                end
            end else begin
                k_nxt_s = k + AW_K'(1);
            end
        end else begin
            k_nxt_s = k;
        end
        last_nxt_s = (i_nxt_s == AW_M'(M - 1)) && (j_nxt_s == AW_N'(N - 1)) &&
                     (k_nxt_s == AW_K'(K - 1));
    end

    // Index and last-point registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i    <= {AW_M{1'b0}};
            j    <= {AW_N{1'b0}};
            k    <= {AW_K{1'b0}};
            last <= LAST_AT_ZERO;
        end else begin
            i    <= i_nxt_s;
            j    <= j_nxt_s;
            k    <= k_nxt_s;
            last <= last_nxt_s;
        end
    end

endmodule

// File: rtl/mac_mult_issue.sv
// Issues A/B read addresses in (i,j,k) order and multiplies the returned
// elements; optional signed multiply selected by MAC_MULT_ISSUE_SIGNED_EN.
module mac_mult_issue
    import mac_pkg::*;
#(
    parameter int M                      = DEF_DIM,
    parameter int K                      = DEF_DIM,
    parameter int N                      = DEF_DIM,
    parameter int DATA_WIDTH_INIT_MATRIX = DEF_DW
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  start,
    input  logic                                  stall_in,
    output logic [addr_w(M)-1:0]                  row_addr_a,
    output logic [addr_w(K)-1:0]                  col_addr_a,
    output logic [addr_w(K)-1:0]                  row_addr_b,
    output logic [addr_w(N)-1:0]                  col_addr_b,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_b,
    output logic [prod_w(DATA_WIDTH_INIT_MATRIX)-1:0] product_reg,
    output logic [addr_w(M)-1:0]                  matrix_a_row_addr_counter_reg,
    output logic [addr_w(K)-1:0]                  matrix_a_col_addr_counter_reg,
    output logic [addr_w(K)-1:0]                  matrix_b_row_addr_counter_reg,
    output logic [addr_w(N)-1:0]                  matrix_b_col_addr_counter_reg,
    output logic                                  mult_done_reg,
    output logic                                  busy,
    output logic                                  done
);

    localparam int DW   = DATA_WIDTH_INIT_MATRIX;
    localparam int PW   = prod_w(DW);
    localparam int AW_M = addr_w(M);
    localparam int AW_N = addr_w(N);
    localparam int AW_K = addr_w(K);

    mac_state_t      state_r;
    logic [AW_M-1:0] cnt_i_s;
    logic [AW_N-1:0] cnt_j_s;
    logic [AW_K-1:0] cnt_k_s;
    logic            cnt_last_s;
    logic            issue_s;

    logic            v0_r;
    logic            v1_r;
    logic [AW_M-1:0] t1_i_r;
    logic [AW_K-1:0] t1_ka_r;
    logic [AW_K-1:0] t1_kb_r;
    logic [AW_N-1:0] t1_j_r;

    logic            hold_vld_r;
    logic [DW-1:0]   hold_a_r;
    logic [DW-1:0]   hold_b_r;
    logic [DW-1:0]   op_a_s;
    logic [DW-1:0]   op_b_s;
    logic [PW-1:0]   ext_a_s;
    logic [PW-1:0]   ext_b_s;
    logic [PW-1:0]   prod_s;

    assign issue_s = (state_r == ST_ISSUE) && !stall_in;

    mac_addr_counter #(
        .M (M),
        .K (K),
        .N (N)
    ) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .enable (issue_s),
        .i      (cnt_i_s),
        .j      (cnt_j_s),
        .k      (cnt_k_s),
        .last   (cnt_last_s)
    );

    // Pass sequencing with registered busy/done
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= ST_ISSUE;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    if (issue_s && cnt_last_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    if (!stall_in && !v0_r && !v1_r) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Address stage: addresses stay put whenever nothing new is issued
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_addr_a <= {AW_M{1'b0}};
            col_addr_a <= {AW_K{1'b0}};
            row_addr_b <= {AW_K{1'b0}};
            col_addr_b <= {AW_N{1'b0}};
            v0_r       <= 1'b0;
        end else if (issue_s) begin
            row_addr_a <= cnt_i_s;
            col_addr_a <= cnt_k_s;
            row_addr_b <= cnt_k_s;
            col_addr_b <= cnt_j_s;
            v0_r       <= 1'b1;
        end else if (!stall_in) begin
            v0_r       <= 1'b0;
        end else begin
            v0_r       <= v0_r;
        end
    end

    // Data stage: tags travel alongside the memory read latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1_r    <= 1'b0;
            t1_i_r  <= {AW_M{1'b0}};
            t1_ka_r <= {AW_K{1'b0}};
            t1_kb_r <= {AW_K{1'b0}};
            t1_j_r  <= {AW_N{1'b0}};
        end else if (!stall_in) begin
            v1_r    <= v0_r;
            t1_i_r  <= row_addr_a;
            t1_ka_r <= col_addr_a;
            t1_kb_r <= row_addr_b;
            t1_j_r  <= col_addr_b;
        end else begin
            v1_r    <= v1_r;
        end
    end

    // On stall entry the memory starts returning the next address's data,
    // so the data belonging to the frozen data stage is captured here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_vld_r <= 1'b0;
            hold_a_r   <= {DW{1'b0}};
            hold_b_r   <= {DW{1'b0}};
        end else if (stall_in && !hold_vld_r) begin
            hold_vld_r <= 1'b1;
            hold_a_r   <= data_in_a;
            hold_b_r   <= data_in_b;
        end else if (!stall_in) begin
            hold_vld_r <= 1'b0;
        end else begin
            hold_vld_r <= hold_vld_r;
        end
    end

    // Operand select and full-width multiply
    always_comb begin
        if (hold_vld_r) begin
            op_a_s = hold_a_r;
            op_b_s = hold_b_r;
        end else begin
            op_a_s = data_in_a;
            op_b_s = data_in_b;
        end
`ifdef MAC_MULT_ISSUE_SIGNED_EN
        ext_a_s = {{DW{op_a_s[DW-1]}}, op_a_s};
        ext_b_s = {{DW{op_b_s[DW-1]}}, op_b_s};
`else
        ext_a_s = {{DW{1'b0}}, op_a_s};
        ext_b_s = {{DW{1'b0}}, op_b_s};
`endif
        prod_s = ext_a_s * ext_b_s;
    end

    // Product stage: product and tags change only with a valid product
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            product_reg                   <= {PW{1'b0}};
            matrix_a_row_addr_counter_reg <= {AW_M{1'b0}};
            matrix_a_col_addr_counter_reg <= {AW_K{1'b0}};
            matrix_b_row_addr_counter_reg <= {AW_K{1'b0}};
            matrix_b_col_addr_counter_reg <= {AW_N{1'b0}};
            mult_done_reg                 <= 1'b0;
        end else if (!stall_in) begin
            mult_done_reg <= v1_r;
            if (v1_r) begin
                product_reg                   <= prod_s;
                matrix_a_row_addr_counter_reg <= t1_i_r;
                matrix_a_col_addr_counter_reg <= t1_ka_r;
                matrix_b_row_addr_counter_reg <= t1_kb_r;
                matrix_b_col_addr_counter_reg <= t1_j_r;
            end else begin
                product_reg <= product_reg;
            end
        end else begin
            mult_done_reg <= mult_done_reg;
        end
    end

endmodule

// File: tb/tb_mac_mult_issue.sv
// Directed bench for mac_mult_issue at M=K=N=4, 32-bit elements, with a
// synchronous-read memory model behind the address ports.
module tb_mac_mult_issue;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        stall_in;
    logic [1:0]  row_addr_a, col_addr_a, row_addr_b, col_addr_b;
    logic [DW-1:0] data_in_a, data_in_b;
    logic [63:0] product_reg;
    logic [1:0]  tag_ia, tag_ka, tag_kb, tag_jb;
    logic        mult_done_reg, busy, done;

    logic [7:0]  cur_tag;
    logic [7:0]  cur_addr;
    assign cur_tag  = {tag_ia, tag_ka, tag_kb, tag_jb};
    assign cur_addr = {row_addr_a, col_addr_a, row_addr_b, col_addr_b};

    mac_mult_issue #(
        .M (4), .K (4), .N (4), .DATA_WIDTH_INIT_MATRIX (DW)
    ) dut (
        .clk                           (clk),
        .resetn                        (resetn),
        .start                         (start),
        .stall_in                      (stall_in),
        .row_addr_a                    (row_addr_a),
        .col_addr_a                    (col_addr_a),
        .row_addr_b                    (row_addr_b),
        .col_addr_b                    (col_addr_b),
        .data_in_a                     (data_in_a),
        .data_in_b                     (data_in_b),
        .product_reg                   (product_reg),
        .matrix_a_row_addr_counter_reg (tag_ia),
        .matrix_a_col_addr_counter_reg (tag_ka),
        .matrix_b_row_addr_counter_reg (tag_kb),
        .matrix_b_col_addr_counter_reg (tag_jb),
        .mult_done_reg                 (mult_done_reg),
        .busy                          (busy),
        .done                          (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem_a [0:3][0:3];
    logic [DW-1:0] mem_b [0:3][0:3];

    always @(posedge clk) begin
        data_in_a <= mem_a[row_addr_a][col_addr_a];
        data_in_b <= mem_b[row_addr_b][col_addr_b];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [63:0] got_p [0:63];
    logic [7:0]  got_t [0:63];
    int got_cnt, gap_cnt, last_cyc, done_cyc;

    function automatic logic [63:0] exp_p(input int n);
        int ii = n / 16;
        int jj = (n / 4) % 4;
        int kk = n % 4;
`ifdef MAC_MULT_ISSUE_SIGNED_EN
        logic signed [63:0] sa = $signed(mem_a[ii][kk]);
        logic signed [63:0] sb = $signed(mem_b[kk][jj]);
        return sa * sb;
`else
        logic [63:0] ua = mem_a[ii][kk];
        logic [63:0] ub = mem_b[kk][jj];
        return ua * ub;
`endif
    endfunction

    function automatic logic [7:0] tag_of(input int n);
        logic [1:0] i2 = 2'(n / 16);
        logic [1:0] j2 = 2'((n / 4) % 4);
        logic [1:0] k2 = 2'(n % 4);
        return {i2, k2, k2, j2};
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (mode)
                    0: begin mem_a[i][j] = 32'd2; mem_b[i][j] = 32'd3; end
                    1: begin mem_a[i][j] = 32'(4 * i + j); mem_b[i][j] = 32'(i + j); end
                    default: begin mem_a[i][j] = 32'hFFFF_FFFF; mem_b[i][j] = 32'hFFFF_FFFF; end
                endcase
            end
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_prod"}, product_reg, 64'd0);
        chk({pfx, "_tag"}, {56'd0, cur_tag}, 64'd0);
        chk({pfx, "_addr"}, {56'd0, cur_addr}, 64'd0);
        chk({pfx, "_vld"}, {63'd0, mult_done_reg}, 64'd0);
        chk({pfx, "_busy"}, {63'd0, busy}, 64'd0);
        chk({pfx, "_done"}, {63'd0, done}, 64'd0);
    endtask

    // One pass: optional stall after product stall_at, reset at abort_at,
    // extra start pulse at restart_at. Returns at the done pulse.
    task automatic run_pass(input int stall_at, input int stall_len,
                            input int abort_at, input int restart_at);
        int cyc = 0;
        int stall_left = 0;
        logic es;
        logic seen_done = 1'b0;
        logic [63:0] held_p = 64'd0;
        logic [7:0]  held_t = 8'd0;
        logic [7:0]  held_a = 8'd0;
        got_cnt = 0; gap_cnt = 0; last_cyc = -1; done_cyc = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!seen_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            es = stall_in;
            if (es) begin
                chk("hold_prod", product_reg, held_p);
                chk("hold_tag", {56'd0, cur_tag}, {56'd0, held_t});
                chk("hold_addr", {56'd0, cur_addr}, {56'd0, held_a});
                chk("hold_vld", {63'd0, mult_done_reg}, 64'd1);
                stall_left--;
                if (stall_left == 0) stall_in = 1'b0;
            end else if (mult_done_reg) begin
                if (got_cnt < 64) begin
                    got_p[got_cnt] = product_reg;
                    got_t[got_cnt] = cur_tag;
                end
                got_cnt++;
                last_cyc = cyc;
                if (got_cnt == 10) chk("busy_mid", {63'd0, busy}, 64'd1);
                if (got_cnt == stall_at && stall_len > 0) begin
                    stall_in = 1'b1; stall_left = stall_len;
                    held_p = product_reg; held_t = cur_tag; held_a = cur_addr;
                end
                if (got_cnt == restart_at) start = 1'b1;
                if (got_cnt == abort_at) begin
                    resetn = 1'b0;
                    #1;
                    chk_zero("abort");
                    return;
                end
            end else if (got_cnt > 0 && got_cnt < 64) begin
                gap_cnt++;
            end
            if (done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end
        end
        if (!seen_done) chk("done_seen", 64'd0, 64'd1);
    endtask

    task automatic post_pass(input logic start_on_done);
        chk("strobes", 64'(got_cnt), 64'd64);
        chk("gap", 64'(gap_cnt), 64'd0);
        chk("done_lat", 64'(done_cyc), 64'(last_cyc + 1));
        if (start_on_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", {63'd0, done}, 64'd0);
        chk("busy_end", {63'd0, busy}, 64'd0);
        chk("vld_end", {63'd0, mult_done_reg}, 64'd0);
        @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        for (int n = 0; n < 64; n++) begin
            chk($sformatf("prod%0d", n), got_p[n], exp_p(n));
            chk($sformatf("tag%0d", n), {56'd0, got_t[n]}, {56'd0, tag_of(n)});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; start = 1'b0; stall_in = 1'b0;
        fill(1);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        resetn = 1'b1;

        // constant pass
        fill(0);
        run_pass(0, 0, 0, 0);
        post_pass(1'b0);
        chk("const_val", got_p[0], 64'd6);

        // ordering, start while busy and start during done
        fill(1);
        run_pass(0, 0, 0, 10);
        post_pass(1'b1);
        chk("ord_t1", {56'd0, got_t[0]}, 64'h00);
        chk("ord_p1", got_p[0], 64'd0);
        chk("ord_t5", {56'd0, got_t[4]}, 64'h01);
        chk("ord_p5", got_p[4], 64'd0);
        chk("ord_t6", {56'd0, got_t[5]}, 64'h15);
        chk("ord_p6", got_p[5], 64'd2);
        chk("ord_t64", {56'd0, got_t[63]}, 64'hFF);
        chk("ord_p64", got_p[63], 64'd90);

        // stall at the 6th product
        run_pass(6, 3, 0, 0);
        post_pass(1'b0);

        // extreme operands
        fill(2);
        run_pass(0, 0, 0, 0);
        post_pass(1'b0);
`ifdef MAC_MULT_ISSUE_SIGNED_EN
        chk("ext_first", got_p[0], 64'd1);
        chk("ext_last", got_p[63], 64'd1);
`else
        chk("ext_first", got_p[0], 64'hFFFF_FFFE_0000_0001);
        chk("ext_last", got_p[63], 64'hFFFF_FFFE_0000_0001);
`endif

        // reset mid-pass, then a clean pass from (0,0,0)
        fill(1);
        run_pass(0, 0, 20, 0);
        repeat (2) @(negedge clk);
        chk_zero("rst_hold");
        resetn = 1'b1;
        run_pass(0, 0, 0, 0);
        post_pass(1'b0);
        chk("rst_first_tag", {56'd0, got_t[0]}, 64'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_mult_issue.md
MAC_MULT_ISSUE -- requirements
Module: mac_mult_issue

Interface
REQ-001 SHALL have parameter M, default 4, rows of matrix A and of matrix C.
REQ-002 SHALL have parameter K, default 4, columns of A and rows of B (inner dimension).
REQ-003 SHALL have parameter N, default 4, columns of matrix B and of matrix C.
REQ-004 SHALL have parameter DATA_WIDTH_INIT_MATRIX, default 32, element width of A and B.
REQ-005 SHALL have one clock; reset is asynchronous and active-low, with ports named as follows:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
REQ-006 SHALL have the following remaining ports:
- start  in  1  one-cycle request to begin a full C = A x B issue pass.
- stall_in  in  1  backpressure from the accumulator; freezes the block.
- row_addr_a / col_addr_a  out  clog2(M) / clog2(K)  A read address.
- row_addr_b / col_addr_b  out  clog2(K) / clog2(N)  B read address.
- data_in_a / data_in_b  in  DATA_WIDTH_INIT_MATRIX  synchronous-read memory data, valid 1 cycle after address.
- product_reg  out  2*DATA_WIDTH_INIT_MATRIX  registered A x B element product.
- matrix_a_row_addr_counter_reg  out  clog2(M)  i tag of product_reg.
- matrix_a_col_addr_counter_reg  out  clog2(K)  k tag of product_reg.
- matrix_b_row_addr_counter_reg  out  clog2(K)  k tag (equal to the A column tag).
- matrix_b_col_addr_counter_reg  out  clog2(N)  j tag of product_reg.
- mult_done_reg  out  1  product_reg and its tags are valid this cycle.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at the end of a pass.

Function
REQ-007 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE -> ISSUE on start.
- ISSUE -> DRAIN after the last address is issued.
- DRAIN -> DONE when the pipeline is empty.
- DONE -> IDLE unconditionally after one cycle.
REQ-008 SHALL issue exactly M*N*K address pairs per pass, in (i, j, k) order.
- i (A row) is outermost, then j (B column), then k innermost; each counter is ascending.
- A address = (i, k); B address = (k, j).
REQ-009 SHALL produce product_reg two cycles after its address: address cycle t, data cycle t+1, product_reg/mult_done_reg valid cycle t+2.
REQ-010 SHALL carry the tags (i, k, k, j) down the pipeline aligned with their product.
REQ-011 SHALL issue one address per cycle when not stalled, giving M*N*K consecutive mult_done_reg cycles.
REQ-012 SHALL, while stall_in=1, hold the address registers, pipeline registers, product_reg, tags and mult_done_reg.
- No product is dropped or duplicated.
- Address outputs stay constant, so re-read data stays consistent.
REQ-013 SHALL deassert mult_done_reg when no valid product is present; product_reg then holds its last value.
REQ-014 SHALL assert busy in ISSUE and DRAIN, and pulse done in DONE, one cycle after the final mult_done_reg cycle.
REQ-015 SHALL ignore start outside IDLE; start coinciding with DONE is ignored.
REQ-016 SHALL wrap each counter at its bound-1 (non-power-of-two bounds included) and carry into the next outer counter.
REQ-017 SHALL form the full-width product without truncation.

Reset
REQ-018 SHALL, when resetn=0 at any time, including mid-pass, asynchronously clear the FSM to IDLE and every output to 0.
- Outputs cleared: addresses, product_reg, tags, mult_done_reg, busy, done.
REQ-019 SHALL, after reset release, start the next pass at (0,0,0).

Configuration
REQ-020 SHALL use macro MAC_MULT_ISSUE_SIGNED_EN to select multiplier signedness.
- Defined: operands are two's-complement signed and the product is signed.
- Undefined: operands and product are unsigned.

Structure
REQ-021 SHALL take the FSM state enum and width helper constants (product width, per-dimension address widths) from a shared package mac_pkg.
REQ-022 SHALL implement the nested i/j/k counting in sub-module mac_addr_counter.
- Inputs: enable.
- Outputs: i, j, k, last.

Verification (M=K=N=4, DATA_WIDTH_INIT_MATRIX=32)
REQ-023 SHALL test a constant pass: A all 2, B all 3, start pulse -> 64 consecutive mult_done_reg cycles, product_reg=6, done one cycle after the last.
REQ-024 SHALL test ordering: A[i][k]=4i+k, B[k][j]=k+j.
- First product: tags (0,0,0,0), value 0.
- Fifth product: tags (0,0,0,1), value 0*1=0; sixth: (0,1,1,1), value 1*2=2.
- 64th product: tags (3,3,3,3), value 15*6=90.
REQ-025 SHALL test stall: stall_in=1 for 3 cycles at the 6th product -> product_reg and tags held, no duplicate, 64 strobes in total.
REQ-026 SHALL test extreme operands: A=B=0xFFFFFFFF.
- Unsigned build -> 0xFFFFFFFE00000001.
- MAC_MULT_ISSUE_SIGNED_EN build -> 1.
REQ-027 SHALL test reset and start handling.
- resetn low at the 20th product -> all outputs 0 immediately.
- New start after release -> first tags (0,0,0,0).
- start while busy -> no effect.
